// File: rtl/tlc_phase_scheduler_pkg.sv
// Shared definitions for the four-way junction phase scheduler: state codes,
// lamp codes, approach indices and small helpers for lamp words and green time.
// Optional feature macro used by the scheduler: TLC_STARVE_GUARD_EN.
package tlc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_CLEAR  = 3'd4
  } tlc_state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [11:0] ALL_RED = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};

  localparam logic [1:0] APP_A = 2'd0;
  localparam logic [1:0] APP_B = 2'd1;
  localparam logic [1:0] APP_C = 2'd2;
  localparam logic [1:0] APP_D = 2'd3;

  // All-red word with one approach's field replaced; a owns the top field.
  function automatic logic [11:0] lamp_word(input logic [1:0] idx, input logic [2:0] code);
    logic [11:0] w;
    w = ALL_RED;
    case (idx)
      APP_A:   w[11:9] = code;
      APP_B:   w[8:6]  = code;
      APP_C:   w[5:3]  = code;
      APP_D:   w[2:0]  = code;
      default: w = ALL_RED;
    endcase
    return w;
  endfunction

  // Green length in ticks, saturated to the 8-bit timer range.
  function automatic logic [7:0] green_ticks(input int base, input int step, input logic [2:0] dens);
    int t;
    t = base + step * int'(dens);
    if (t > 255) t = 255;
    return t[7:0];
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Sensor-side inputs and lamp-side outputs of the phase scheduler.
// Timing contract: there is no valid/ready handshake here. tick is a one-clock
// strobe that advances every timer; req, ss and the densities are level inputs
// sampled on every clock; all outputs are registered and change only on the
// clock edge (or immediately on reset).
interface tlc_phase_scheduler_if;
  logic        tick;
  logic [2:0]  dens_a;
  logic [2:0]  dens_b;
  logic [2:0]  dens_c;
  logic [2:0]  dens_d;
  logic [3:0]  req;
  logic [3:0]  ss;
  logic [11:0] ID;
  logic [2:0]  state;
  logic [1:0]  grant_idx;
  logic        phase_done;

  modport master (
    output tick, dens_a, dens_b, dens_c, dens_d, req, ss,
    input  ID, state, grant_idx, phase_done
  );

  modport slave (
    input  tick, dens_a, dens_b, dens_c, dens_d, req, ss,
    output ID, state, grant_idx, phase_done
  );
endinterface

// File: rtl/tlc_phase_scheduler_rr_pick.sv
// Combinational picker: among the set bits of mask, return the one with the
// highest density; ties go to the first candidate after start in round-robin
// order (start itself is considered last).
module tlc_rr_pick (
  input  logic [3:0]      mask,
  input  logic [3:0][2:0] dens,
  input  logic [1:0]      start,
  output logic [1:0]      idx,
  output logic            valid
);

  logic [1:0] pos;
  logic [2:0] best;

  // Walk the four approaches from start+1; strict '>' keeps the earliest tie.
  always_comb begin
    idx   = start;
    valid = 1'b0;
    best  = 3'd0;
    pos   = start;
    for (int k = 1; k <= 4; k++) begin
      pos = start + 2'(k);
      if (mask[pos] && (!valid || (dens[pos] > best))) begin
        valid = 1'b1;
        idx   = pos;
        best  = dens[pos];
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Timed phase scheduler for a four-way junction: picks an approach by special
// signal, then queue density with round-robin tie-break, and runs it through
// green, yellow and all-red clearance. Lamp word is registered.
// Optional macro TLC_STARVE_GUARD_EN adds per-approach skip counters that force
// a long-waiting approach ahead of density.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int GREEN_BASE = 4,
  parameter int GREEN_STEP = 2,
  parameter int YELLOW_T   = 2,
  parameter int CLEAR_T    = 1
`ifdef TLC_STARVE_GUARD_EN
  , parameter int SKIP_MAX = 3
`endif
) (
  input logic               clock,
  input logic               clear,
  tlc_phase_scheduler_if.slave bus
);

  tlc_state_e  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  grant_q, grant_d;
  logic [11:0] id_q, id_d;
  logic        done_q, done_d;
  logic        emg_v_q, emg_v_d;
  logic [1:0]  emg_idx_q, emg_idx_d;

  logic [3:0][2:0] dens_vec;
  logic [3:0]      ss_mask;
  logic [1:0]      ss_idx, req_idx, pick_idx;
  logic            ss_v, req_v, pick_v;

  assign dens_vec = {bus.dens_d, bus.dens_c, bus.dens_b, bus.dens_a};

  // While green, the served approach's own ss only freezes the timer, so it is
  // masked out of the pre-empt search.
  assign ss_mask = (state_q == S_GREEN) ? (bus.ss & ~(4'b0001 << grant_q)) : bus.ss;

  tlc_rr_pick u_ss_pick (
    .mask (ss_mask),
    .dens ('0),
    .start(grant_q),
    .idx  (ss_idx),
    .valid(ss_v)
  );

  tlc_rr_pick u_req_pick (
    .mask (bus.req),
    .dens (dens_vec),
    .start(grant_q),
    .idx  (req_idx),
    .valid(req_v)
  );

`ifdef TLC_STARVE_GUARD_EN
  logic [3:0][1:0] skip_q, skip_d;
  logic [3:0]      starve_mask;
  logic [1:0]      starve_idx;
  logic            starve_v;

  // Approaches that have been passed over SKIP_MAX times are candidates.
  always_comb begin
    starve_mask = '0;
    for (int i = 0; i < 4; i++) starve_mask[i] = (int'(skip_q[i]) >= SKIP_MAX);
  end

  tlc_rr_pick u_starve_pick (
    .mask (starve_mask),
    .dens ('0),
    .start(grant_q),
    .idx  (starve_idx),
    .valid(starve_v)
  );

  // Count SELECTs in which a requester lost; clear on being served.
  always_comb begin
    skip_d = skip_q;
    if (state_q == S_SELECT && pick_v) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == pick_idx)                    skip_d[i] = 2'd0;
        else if (bus.req[i] && skip_q[i] != 2'd3) skip_d[i] = skip_q[i] + 2'd1;
      end
    end
  end

  // Skip counter register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) skip_q <= '0;
    else       skip_q <= skip_d;
  end
`endif

  // Selection priority: latched emergency owner, live ss, starvation, density.
  always_comb begin
    pick_v   = 1'b0;
    pick_idx = grant_q;
    if (emg_v_q) begin
      pick_v   = 1'b1;
      pick_idx = emg_idx_q;
    end else if (ss_v) begin
      pick_v   = 1'b1;
      pick_idx = ss_idx;
    end
`ifdef TLC_STARVE_GUARD_EN
    else if (starve_v) begin
      pick_v   = 1'b1;
      pick_idx = starve_idx;
    end
`endif
    else if (req_v) begin
      pick_v   = 1'b1;
      pick_idx = req_idx;
    end
  end

  // Next-state, timer, grant, emergency latch and registered lamp word.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    emg_v_d   = emg_v_q;
    emg_idx_d = emg_idx_q;
    case (state_q)
      S_IDLE: begin
        timer_d = 8'd0;
        if (|bus.req || |bus.ss) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (pick_v) begin
          state_d = S_GREEN;
          grant_d = pick_idx;
          timer_d = green_ticks(GREEN_BASE, GREEN_STEP, dens_vec[pick_idx]);
          emg_v_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          timer_d = 8'd0;
        end
      end
      S_GREEN: begin
        if (ss_v) begin
          // Pre-empt does not wait for tick and beats a coincident tick.
          state_d   = S_YELLOW;
          timer_d   = 8'(YELLOW_T);
          emg_v_d   = 1'b1;
          emg_idx_d = ss_idx;
        end else if (bus.tick && !bus.ss[grant_q]) begin
          if (timer_q <= 8'd1) begin
            state_d = S_YELLOW;
            timer_d = 8'(YELLOW_T);
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      S_YELLOW: begin
        if (bus.tick) begin
          if (timer_q <= 8'd1) begin
            state_d = S_CLEAR;
            timer_d = 8'(CLEAR_T);
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      S_CLEAR: begin
        if (bus.tick) begin
          if (timer_q <= 8'd1) begin
            state_d = S_SELECT;
            timer_d = 8'd0;
            done_d  = 1'b1;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 8'd0;
      end
    endcase

    case (state_d)
      S_GREEN:  id_d = lamp_word(grant_d, LAMP_GRN);
      S_YELLOW: id_d = lamp_word(grant_d, LAMP_YEL);
      default:  id_d = ALL_RED;
    endcase
  end

  // State register; reset drops straight to all red.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      timer_q   <= 8'd0;
      grant_q   <= APP_D;
      id_q      <= ALL_RED;
      done_q    <= 1'b0;
      emg_v_q   <= 1'b0;
      emg_idx_q <= APP_A;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      done_q    <= done_d;
      emg_v_q   <= emg_v_d;
      emg_idx_q <= emg_idx_d;
    end
  end

  assign bus.ID         = id_q;
  assign bus.state      = state_q;
  assign bus.grant_idx  = grant_q;
  assign bus.phase_done = done_q;

endmodule
